// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - command encodings shared by the multi-channel accumulator
package acc_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_ADD   = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB   = 2'b01;
    localparam logic [OP_W-1:0] OP_LOAD  = 2'b10;
    localparam logic [OP_W-1:0] OP_CLEAR = 2'b11;

endpackage

// File: rtl/acc_lane.sv
// rtl/acc_lane.sv - next-value and overflow logic for one accumulator channel
module acc_lane
    import acc_pkg::*;
#(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 8,
    parameter int SATURATE  = 1
) (
    input  logic [OP_W-1:0]      op,
    input  logic [IN_WIDTH-1:0]  d_in,
    input  logic [OUT_WIDTH-1:0] acc_q,
    output logic [OUT_WIDTH-1:0] acc_d,
    output logic                 ovf_set,
    output logic                 ovf_clr
);

    logic [OUT_WIDTH-1:0] d_ext;
    logic [OUT_WIDTH:0]   sum;
    logic [OUT_WIDTH:0]   diff;

    assign d_ext = OUT_WIDTH'(d_in);
    // The extra top bit is the carry for ADD and the borrow for SUB.
    assign sum   = {1'b0, acc_q} + {1'b0, d_ext};
    assign diff  = {1'b0, acc_q} - {1'b0, d_ext};

    always_comb begin
        acc_d   = acc_q;
        ovf_set = 1'b0;
        ovf_clr = 1'b0;
        case (op)
            OP_ADD: begin
                ovf_set = sum[OUT_WIDTH];
                if (sum[OUT_WIDTH] && (SATURATE != 0)) acc_d = '1;
                else                                   acc_d = sum[OUT_WIDTH-1:0];
            end
            OP_SUB: begin
                ovf_set = diff[OUT_WIDTH];
                if (diff[OUT_WIDTH] && (SATURATE != 0)) acc_d = '0;
                else                                    acc_d = diff[OUT_WIDTH-1:0];
            end
            OP_LOAD: begin
                acc_d   = d_ext;
                ovf_clr = 1'b1;
            end
            default: begin
                acc_d   = '0;
                ovf_clr = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/acc_multi_chan.sv
// rtl/acc_multi_chan.sv - CHANNELS independent accumulators with read and echo ports
module acc_multi_chan
    import acc_pkg::*;
#(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 8,
    parameter int CHANNELS  = 4,
    parameter int SATURATE  = 1,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [CW-1:0]        in_ch,
    input  logic [OP_W-1:0]      op,
    input  logic [IN_WIDTH-1:0]  d_in,
    input  logic [CW-1:0]        rd_ch,
    output logic [OUT_WIDTH-1:0] d_out,
    output logic                 out_valid,
    output logic [CW-1:0]        out_ch,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]  ovf,
    output logic                 err
);

    localparam logic [CW:0] CH_LIMIT = (CW + 1)'(CHANNELS);

    logic [OUT_WIDTH-1:0] acc_q [CHANNELS];
    logic [OUT_WIDTH-1:0] acc_d [CHANNELS];
    logic [CHANNELS-1:0]  ovf_d;
    logic [OUT_WIDTH-1:0] acc_sel;
    logic [OUT_WIDTH-1:0] lane_acc;
    logic                 lane_set;
    logic                 lane_clr;
    logic [OUT_WIDTH-1:0] rd_next;
    logic                 cmd_ok;

    // The index can exceed CHANNELS-1 when CHANNELS is not a power of two.
    assign cmd_ok = in_valid && ({1'b0, in_ch} < CH_LIMIT);

    always_comb begin
        acc_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_ch == CW'(i)) acc_sel = acc_q[i];
        end
    end

    acc_lane #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .SATURATE (SATURATE)
    ) u_lane (
        .op     (op),
        .d_in   (d_in),
        .acc_q  (acc_sel),
        .acc_d  (lane_acc),
        .ovf_set(lane_set),
        .ovf_clr(lane_clr)
    );

    always_comb begin
        ovf_d = ovf;
        for (int i = 0; i < CHANNELS; i++) begin
            acc_d[i] = acc_q[i];
            if (cmd_ok && (in_ch == CW'(i))) begin
                acc_d[i] = lane_acc;
                ovf_d[i] = lane_clr ? 1'b0 : (ovf[i] | lane_set);
            end
        end
    end

    // Read from the next-state array so a same-edge write is visible (write-first).
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_ch == CW'(i)) rd_next = acc_d[i];
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
            ovf       <= '0;
            d_out     <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) acc_q[i] <= acc_d[i];
            ovf       <= ovf_d;
            d_out     <= rd_next;
            out_valid <= cmd_ok;
            err       <= in_valid && !cmd_ok;
            if (cmd_ok) begin
                out_ch   <= in_ch;
                out_data <= lane_acc;
            end
        end
    end

endmodule

// File: tb/tb_acc_multi_chan.sv
// tb/tb_acc_multi_chan.sv - bench for saturating, wrapping and three-channel builds
module tb_acc_multi_chan;
    import acc_pkg::*;

    logic       clock;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_ch;
    logic [1:0] op;
    logic [3:0] d_in;
    logic [1:0] rd_ch;

    logic [7:0] d_out_s, out_data_s, d_out_w, out_data_w, d_out_c, out_data_c;
    logic       out_valid_s, err_s, out_valid_w, err_w, out_valid_c, err_c;
    logic [1:0] out_ch_s, out_ch_w, out_ch_c;
    logic [3:0] ovf_s, ovf_w;
    logic [2:0] ovf_c;

    acc_multi_chan #(.SATURATE(1)) u_sat (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .op(op),
        .d_in(d_in), .rd_ch(rd_ch), .d_out(d_out_s), .out_valid(out_valid_s),
        .out_ch(out_ch_s), .out_data(out_data_s), .ovf(ovf_s), .err(err_s)
    );
    acc_multi_chan #(.SATURATE(0)) u_wrap (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .op(op),
        .d_in(d_in), .rd_ch(rd_ch), .d_out(d_out_w), .out_valid(out_valid_w),
        .out_ch(out_ch_w), .out_data(out_data_w), .ovf(ovf_w), .err(err_w)
    );
    acc_multi_chan #(.CHANNELS(3)) u_ch3 (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .op(op),
        .d_in(d_in), .rd_ch(rd_ch), .d_out(d_out_c), .out_valid(out_valid_c),
        .out_ch(out_ch_c), .out_data(out_data_c), .ovf(ovf_c), .err(err_c)
    );

    logic [7:0] o_dout [3];
    logic [7:0] o_data [3];
    logic [1:0] o_ch   [3];
    logic [3:0] o_ovf  [3];
    logic       o_valid[3];
    logic       o_err  [3];

    assign o_dout[0] = d_out_s;    assign o_dout[1] = d_out_w;    assign o_dout[2] = d_out_c;
    assign o_data[0] = out_data_s; assign o_data[1] = out_data_w; assign o_data[2] = out_data_c;
    assign o_ch[0]   = out_ch_s;   assign o_ch[1]   = out_ch_w;   assign o_ch[2]   = out_ch_c;
    assign o_ovf[0]  = ovf_s;      assign o_ovf[1]  = ovf_w;      assign o_ovf[2]  = {1'b0, ovf_c};
    assign o_valid[0] = out_valid_s; assign o_valid[1] = out_valid_w; assign o_valid[2] = out_valid_c;
    assign o_err[0]  = err_s;      assign o_err[1]  = err_w;      assign o_err[2]  = err_c;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int m_acc [3][4];
    bit m_ovf [3][4];
    int m_nch [3] = '{4, 4, 3};
    bit m_sat [3] = '{1'b1, 1'b0, 1'b1};

    bit e_valid [3];
    bit e_err   [3];
    bit e_dchk  [3];
    int e_ch    [3];
    int e_data  [3];
    int e_dout  [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour: plain integer arithmetic against the 0..255 range.
    task automatic model(input int k);
        int a;
        e_valid[k] = 1'b0;
        e_err[k]   = 1'b0;
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) begin
                m_acc[k][c] = 0;
                m_ovf[k][c] = 1'b0;
            end
            e_ch[k] = 0; e_data[k] = 0; e_dout[k] = 0; e_dchk[k] = 1'b1;
            return;
        end
        if (in_valid) begin
            if (int'(in_ch) >= m_nch[k]) begin
                e_err[k] = 1'b1;
            end else begin
                a = m_acc[k][in_ch];
                case (op)
                    OP_ADD: begin
                        a = a + int'(d_in);
                        if (a > 255) begin
                            m_ovf[k][in_ch] = 1'b1;
                            a = m_sat[k] ? 255 : a - 256;
                        end
                    end
                    OP_SUB: begin
                        a = a - int'(d_in);
                        if (a < 0) begin
                            m_ovf[k][in_ch] = 1'b1;
                            a = m_sat[k] ? 0 : a + 256;
                        end
                    end
                    OP_LOAD: begin a = int'(d_in); m_ovf[k][in_ch] = 1'b0; end
                    default: begin a = 0;          m_ovf[k][in_ch] = 1'b0; end
                endcase
                m_acc[k][in_ch] = a;
                e_valid[k] = 1'b1;
                e_ch[k]    = int'(in_ch);
                e_data[k]  = a;
            end
        end
        e_dchk[k] = int'(rd_ch) < m_nch[k];
        e_dout[k] = e_dchk[k] ? m_acc[k][rd_ch] : 0;
    endtask

    task automatic step(input bit r, input bit v, input int ch, input int o, input int d, input int rd);
        logic [3:0] ev;
        rst_n    = r;
        in_valid = v;
        in_ch    = ch[1:0];
        op       = o[1:0];
        d_in     = d[3:0];
        rd_ch    = rd[1:0];
        for (int k = 0; k < 3; k++) model(k);
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            ev = '0;
            for (int c = 0; c < m_nch[k]; c++) ev[c] = m_ovf[k][c];
            chk($sformatf("valid%0d", k), o_valid[k], e_valid[k]);
            chk($sformatf("err%0d", k), o_err[k], e_err[k]);
            chk($sformatf("ovf%0d", k), o_ovf[k], ev);
            if (e_valid[k] || !r) begin
                chk($sformatf("out_ch%0d", k), o_ch[k], e_ch[k]);
                chk($sformatf("out_data%0d", k), o_data[k], e_data[k]);
            end
            if (e_dchk[k]) chk($sformatf("d_out%0d", k), o_dout[k], e_dout[k]);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; op = '0; d_in = '0; rd_ch = '0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 2, OP_LOAD, 9, 2);

        for (int i = 1; i <= 18; i++) begin
            step(1, 1, 0, OP_ADD, 15, 0);
            if (i == 1)  chk("sat_first", o_data[0], 15);
            if (i == 17) chk("sat_17th", o_data[0], 255);
            if (i == 18) begin
                chk("sat_18th", o_data[0], 255);
                chk("sat_ovf0", o_ovf[0][0], 1);
            end
        end

        step(1, 1, 1, OP_SUB, 3, 1);
        chk("sub_floor", o_data[0], 0);
        chk("sub_ovf1", o_ovf[0][1], 1);
        step(1, 1, 1, OP_LOAD, 5, 1);
        chk("load_val", o_data[0], 5);
        chk("load_ovf1", o_ovf[0][1], 0);

        step(1, 1, 2, OP_ADD, 7, 0);
        chk("ind_a", o_data[0], 7);
        step(1, 1, 3, OP_ADD, 9, 0);
        chk("ind_b", o_data[0], 9);
        chk("inv_err", o_err[2], 1);
        chk("inv_valid", o_valid[2], 0);
        step(1, 1, 2, OP_ADD, 1, 0);
        chk("ind_c", o_data[0], 8);
        step(1, 0, 0, OP_ADD, 0, 3);
        chk("rd_ch3", o_dout[0], 9);

        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, OP_LOAD, 15, 0);
        for (int i = 0; i < 16; i++) step(1, 1, 0, OP_ADD, 15, 0);
        chk("wrap_top", o_data[1], 255);
        step(1, 1, 0, OP_ADD, 1, 0);
        chk("wrap_zero", o_data[1], 0);
        chk("wrap_ovf0", o_ovf[1][0], 1);

        step(1, 1, 0, OP_LOAD, 10, 0);
        step(1, 1, 0, OP_ADD, 2, 0);
        chk("rdw_dout", o_dout[0], 12);
        chk("rdw_data", o_data[0], 12);

        step(1, 1, 1, OP_ADD, 4, 1);
        step(0, 1, 1, OP_ADD, 5, 1);
        chk("rst_dout", o_dout[0], 0);
        chk("rst_valid", o_valid[0], 0);

        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 15), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
